packetizer_rr: RTL and testbench

PACKETIZER_RR -- requirements
Module: packetizer_rr

---
 rtl/packetizer_rr.sv | 155 +++++++++++++++
 tb/tb_packetizer_rr.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/packetizer_rr.sv
// packetizer_rr: round-robin packetizer with an output FIFO.
//
// N_CH source channels each present {addr, op, data} fields. A round-robin
// arbiter grants one channel per cycle while the FIFO has room, and the
// assembled packet plus its source index are queued. The FIFO head drives
// the output side with a valid/ready handshake.
//
// Optional feature: define PACKETIZER_PARITY_EN to add out_parity, which is the
// even-parity XOR of the head packet and is stored alongside each FIFO entry.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   per-channel request / one-hot accept
//   in_addr/op/data     per-channel fields, channel i at [i*W +: W]
//   out_valid/out_ready FIFO head handshake
//   out_packet          {addr, op, data} of the head entry
//   out_src             channel index that produced the head entry
//   fifo_count          occupied FIFO entries
//   out_parity          (PACKETIZER_PARITY_EN only) parity of the head packet
module packetizer_rr #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4,
    parameter int DATA_W = 25,
    parameter int DEPTH  = 4,
    localparam int PKT_W = ADDR_W + OP_W + DATA_W,
    localparam int SRC_W = $clog2(N_CH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic [N_CH*ADDR_W-1:0]   in_addr,
    input  logic [N_CH*OP_W-1:0]     in_op,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PKT_W-1:0]         out_packet,
    output logic [SRC_W-1:0]         out_src,
    output logic [CNT_W-1:0]         fifo_count
`ifdef PACKETIZER_PARITY_EN
    ,
    output logic                     out_parity
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_a [N_CH];
    logic [OP_W-1:0]   op_a   [N_CH];
    logic [DATA_W-1:0] data_a [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign addr_a[i] = in_addr[i*ADDR_W +: ADDR_W];
        assign op_a[i]   = in_op[i*OP_W +: OP_W];
        assign data_a[i] = in_data[i*DATA_W +: DATA_W];
    end

    logic [PKT_W-1:0] mem_pkt_q [DEPTH];
    logic [SRC_W-1:0] mem_src_q [DEPTH];
`ifdef PACKETIZER_PARITY_EN
    logic             mem_par_q [DEPTH];
`endif

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             gnt_found;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W-1:0] cand;
    logic             push;
    logic             pop;
    logic [PKT_W-1:0] push_pkt;

    // Search starts at rr_ptr and wraps modulo N_CH (N_CH need not be a power of two).
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = SRC_W'((int'(rr_ptr_q) + k) % N_CH);
            if (!gnt_found && in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Room is judged on the current count only; a same-cycle pop does not free a slot.
    // rst_n gates the grant so in_ready is forced low while reset is held.
    assign push = gnt_found && (count_q < FULL_CNT) && rst_n;
    assign pop  = (count_q != '0) && out_ready;

    always_comb begin
        in_ready = '0;
        if (push) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign push_pkt = {addr_a[gnt_idx], op_a[gnt_idx], data_a[gnt_idx]};

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rr_ptr_d = push ? SRC_W'((int'(gnt_idx) + 1) % N_CH) : rr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pkt_q[i] <= '0;
                mem_src_q[i] <= '0;
`ifdef PACKETIZER_PARITY_EN
                mem_par_q[i] <= 1'b0;
`endif
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            if (push) begin
                mem_pkt_q[wr_ptr_q] <= push_pkt;
                mem_src_q[wr_ptr_q] <= gnt_idx;
`ifdef PACKETIZER_PARITY_EN
                mem_par_q[wr_ptr_q] <= ^push_pkt;
`endif
            end
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_packet = mem_pkt_q[rd_ptr_q];
    assign out_src    = mem_src_q[rd_ptr_q];
    assign fifo_count = count_q;
`ifdef PACKETIZER_PARITY_EN
    assign out_parity = mem_par_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_packetizer_rr.sv
// Directed testbench for packetizer_rr (default parameters).
// Inputs change on the falling edge; outputs are checked on the falling edge
// (or 1 time unit after an input change for the combinational in_ready).
module tb_packetizer_rr;

    localparam int N_CH   = 4;
    localparam int ADDR_W = 4;
    localparam int OP_W   = 4;
    localparam int DATA_W = 25;
    localparam int DEPTH  = 4;
    localparam int PKT_W  = ADDR_W + OP_W + DATA_W;
    localparam int SRC_W  = $clog2(N_CH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                   clk;
    logic                   rst_n;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_ready;
    logic [N_CH*ADDR_W-1:0] in_addr;
    logic [N_CH*OP_W-1:0]   in_op;
    logic [N_CH*DATA_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [PKT_W-1:0]       out_packet;
    logic [SRC_W-1:0]       out_src;
    logic [CNT_W-1:0]       fifo_count;
`ifdef PACKETIZER_PARITY_EN
    logic                   out_parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    packetizer_rr #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .OP_W(OP_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_op      (in_op),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .out_src    (out_src),
        .fifo_count (fifo_count)
`ifdef PACKETIZER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] pkt(input logic [ADDR_W-1:0] a,
                                              input logic [OP_W-1:0] o,
                                              input logic [DATA_W-1:0] d);
        return {a, o, d};
    endfunction

    task automatic set_ch(input int ch, input logic [ADDR_W-1:0] a,
                          input logic [OP_W-1:0] o, input logic [DATA_W-1:0] d);
        in_addr[ch*ADDR_W +: ADDR_W] = a;
        in_op[ch*OP_W +: OP_W]       = o;
        in_data[ch*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '1;
        in_addr   = '0;
        in_op     = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state (in_valid high during reset must not produce a grant)
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_packet", 64'(out_packet), 64'd0);
        check("rst_src", 64'(out_src), 64'd0);
        in_valid = '0;
        rst_n    = 1'b1;

        // Single-channel accept from ch2
        @(negedge clk);
        set_ch(2, 4'h5, 4'h3, 25'h0000ABC);
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1 check("single_in_ready", 64'(in_ready), 64'b0100);
        @(negedge clk);
        in_valid = '0;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_packet", 64'(out_packet), 64'h0_A600_0ABC);
        check("single_src", 64'(out_src), 64'd2);
        check("single_count", 64'(fifo_count), 64'd1);
        @(negedge clk);
        check("single_drained", 64'(fifo_count), 64'd0);
        check("single_drained_valid", 64'(out_valid), 64'd0);

        // Reset pulse so the round-robin pointer restarts at 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin: all channels valid, downstream always ready
        for (int i = 0; i < N_CH; i++) begin
            set_ch(i, ADDR_W'(i), OP_W'(12 - i), DATA_W'(32'h1000 + i));
        end
        in_valid  = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1 check($sformatf("rr_in_ready_%0d", k), 64'(in_ready), 64'(1 << (k % 4)));
            if (k > 0) begin
                check($sformatf("rr_src_%0d", k), 64'(out_src), 64'((k - 1) % 4));
                check($sformatf("rr_count_%0d", k), 64'(fifo_count), 64'd1);
                check($sformatf("rr_packet_%0d", k), 64'(out_packet),
                      64'(pkt(ADDR_W'((k - 1) % 4), OP_W'(12 - (k - 1) % 4),
                              DATA_W'(32'h1000 + (k - 1) % 4))));
            end
            @(negedge clk);
        end
        in_valid = '0;
        check("rr_last_src", 64'(out_src), 64'd3);
        @(negedge clk);
        check("rr_drained", 64'(fifo_count), 64'd0);

        // Backpressure: ch0 only, downstream stalled, distinct data per accept
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        set_ch(0, 4'h0, 4'hC, 25'h200);
        for (int j = 0; j < 4; j++) begin
            #1 check($sformatf("bp_in_ready_%0d", j), 64'(in_ready), 64'b0001);
            check($sformatf("bp_count_%0d", j), 64'(fifo_count), 64'(j));
            @(negedge clk);
            set_ch(0, 4'h0, 4'hC, DATA_W'(32'h200 + j + 1));
        end
        #1 check("bp_full_count", 64'(fifo_count), 64'd4);
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        check("bp_head_src", 64'(out_src), 64'd0);
        check("bp_head_pkt", 64'(out_packet), 64'(pkt(4'h0, 4'hC, 25'h200)));
        @(negedge clk);
        check("bp_stable_count", 64'(fifo_count), 64'd4);
        check("bp_stable_pkt", 64'(out_packet), 64'(pkt(4'h0, 4'hC, 25'h200)));

        // Full with simultaneous pop: no grant this cycle
        out_ready = 1'b1;
        #1 check("fullpop_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("fullpop_count", 64'(fifo_count), 64'd3);
        check("fullpop_head", 64'(out_packet), 64'(pkt(4'h0, 4'hC, 25'h201)));
        out_ready = 1'b0;
        #1 check("fullpop_regrant", 64'(in_ready), 64'b0001);
        @(negedge clk);
        check("refill_count", 64'(fifo_count), 64'd4);

        // Pop one to reach count=3, then reset mid-burst
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("pre_rst_count", 64'(fifo_count), 64'd3);
        check("pre_rst_head", 64'(out_packet), 64'(pkt(4'h0, 4'hC, 25'h202)));
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1 check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(fifo_count), 64'd0);
        check("midrst_packet", 64'(out_packet), 64'd0);
        in_valid = 4'b1010;
        #1 check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("postrst_grant", 64'(in_ready), 64'b0010);
        @(negedge clk);
        check("postrst_count", 64'(fifo_count), 64'd1);
        check("postrst_src", 64'(out_src), 64'd1);
        check("postrst_pkt", 64'(out_packet), 64'(pkt(4'h1, 4'hB, 25'h1001)));
        #1 check("postrst_grant2", 64'(in_ready), 64'b1000);
        @(negedge clk);
        check("postrst_count2", 64'(fifo_count), 64'd2);
        #1 check("postrst_wrap", 64'(in_ready), 64'b0010);
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("final_drain", 64'(fifo_count), 64'd0);
        check("final_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

`ifdef PACKETIZER_PARITY_EN
        set_ch(0, 4'h0, 4'h0, 25'h1);
        in_valid = 4'b0001;
        @(negedge clk);
        set_ch(0, 4'h0, 4'h0, 25'h3);
        @(negedge clk);
        in_valid = '0;
        check("par_count", 64'(fifo_count), 64'd2);
        check("par_pkt1", 64'(out_packet), 64'h1);
        check("par_one", 64'(out_parity), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("par_pkt3", 64'(out_packet), 64'h3);
        check("par_zero", 64'(out_parity), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
